// File: rtl/input_stream_feeder_pkg.sv
// Shared definitions for the PE_Group stream feeders.
// Holds the feeder FSM encoding and the helpers that derive loop counts
// (tiles, blocks, window length, beats per pass) from the tiling parameters.
package input_stream_feeder_pkg;

  // Feeder FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Number of output tiles walked by the outer loop
  function automatic int isf_o_tiles(input int o_size, input int o_tile);
    return o_size / o_tile;
  endfunction

  // PE-group blocks inside one output tile
  function automatic int isf_o_blocks(input int o_tile, input int o_peg);
    return o_tile / o_peg;
  endfunction

  // Weight tiles walked per output block
  function automatic int isf_w_tiles(input int w_size, input int w_tile);
    return w_size / w_tile;
  endfunction

  // Sliding-window length: one PE group convolved with one weight tile
  function automatic int isf_win_len(input int o_peg, input int w_tile);
    return o_peg + w_tile - 1;
  endfunction

  // Beats delivered in one pass
  function automatic int isf_beats(input int o_size, input int o_tile, input int o_peg,
                                   input int w_size, input int w_tile);
    return isf_o_tiles(o_size, o_tile) * isf_o_blocks(o_tile, o_peg) *
           isf_w_tiles(w_size, w_tile) * isf_win_len(o_peg, w_tile);
  endfunction

  // Counter width for a loop of n iterations (at least one bit)
  function automatic int isf_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/input_stream_feeder_stream_skid_fifo.sv
// stream_skid_fifo: 2-entry stream buffer between a fixed-latency source and a valid/ready sink.
// Latency: a word written in cycle n is visible at the head in cycle n+1.
// Backpressure: the writer must hold its own credit (count_o) and never write a full FIFO
// unless the head is popped that same cycle; full + pop + write keeps the count at two.
// Ports: clk/aclr (sync, active-high); in_vld_i/in_dat_i write side;
//        out_vld_o/out_dat_o/out_rdy_i read side; count_o current occupancy (0..2).
module stream_skid_fifo #(
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 in_vld_i,
  input  logic [DataWidth-1:0] in_dat_i,
  output logic                 out_vld_o,
  output logic [DataWidth-1:0] out_dat_o,
  input  logic                 out_rdy_i,
  output logic [1:0]           count_o
);

  logic [DataWidth-1:0] mem_q [2];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [1:0]           cnt_q;
  logic                 pop;

  assign out_vld_o = (cnt_q != 2'd0);
  assign pop       = out_vld_o && out_rdy_i;
  assign out_dat_o = mem_q[rd_ptr_q];
  assign count_o   = cnt_q;

  always_ff @(posedge clk) begin
    if (aclr) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      // When full, wr_ptr == rd_ptr: a write overwrites the head being popped
      if (in_vld_i) begin
        mem_q[wr_ptr_q] <= in_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({in_vld_i, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/input_stream_feeder.sv
// input_stream_feeder: walks the tiled I-operand address pattern and streams the words to PE_Group.
// Latency: Start sampled at edge n -> first beat valid after edge n+2; then 1 beat/cycle.
// Backpressure: reads are credit-limited to the 2-entry output buffer; stalled beats hold stable.
// Ports: clk/aclr (sync, active-high); Start/Busy/Done pass control; Mem_RdEn/Mem_Addr/Mem_RdData
//        1-cycle-latency memory read port; I_DataOutValid/I_DataOutRdy/I_DataOut output stream.
module input_stream_feeder
  import input_stream_feeder_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 8,
  parameter int O_Size        = 8,
  parameter int O_TileSize    = 4,
  parameter int O_PEGroupSize = 4,
  parameter int W_Size        = 8,
  parameter int W_TileSize    = 8
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 Start,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Mem_RdEn,
  output logic [AddrWidth-1:0] Mem_Addr,
  input  logic [DataWidth-1:0] Mem_RdData,
  output logic                 I_DataOutValid,
  input  logic                 I_DataOutRdy,
  output logic [DataWidth-1:0] I_DataOut
);

  localparam int OTiles  = isf_o_tiles(O_Size, O_TileSize);
  localparam int OBlocks = isf_o_blocks(O_TileSize, O_PEGroupSize);
  localparam int WTiles  = isf_w_tiles(W_Size, W_TileSize);
  localparam int WinLen  = isf_win_len(O_PEGroupSize, W_TileSize);

  localparam int OtW = isf_cnt_w(OTiles);
  localparam int ObW = isf_cnt_w(OBlocks);
  localparam int WtW = isf_cnt_w(WTiles);
  localparam int KW  = isf_cnt_w(WinLen);

  localparam logic [OtW-1:0] OtLast = OtW'(OTiles - 1);
  localparam logic [ObW-1:0] ObLast = ObW'(OBlocks - 1);
  localparam logic [WtW-1:0] WtLast = WtW'(WTiles - 1);
  localparam logic [KW-1:0]  KLast  = KW'(WinLen - 1);

  logic [1:0]     state_q, state_d;
  logic [OtW-1:0] ot_q, ot_d;
  logic [ObW-1:0] ob_q, ob_d;
  logic [WtW-1:0] wt_q, wt_d;
  logic [KW-1:0]  k_q, k_d;
  logic           inflight_q;

  logic [1:0]     fifo_cnt;
  logic           pop;
  logic           issue;
  logic           last_addr;
  logic           drained;

  assign pop = I_DataOutValid && I_DataOutRdy;

  // Credit check counts the slot freed by this cycle's pop, otherwise the
  // pipeline bubbles every other beat with the sink always ready.
  assign issue = (state_q == ST_RUN) &&
                 (({1'b0, fifo_cnt} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

  assign last_addr = (k_q == KLast) && (wt_q == WtLast) && (ob_q == ObLast) && (ot_q == OtLast);
  assign drained   = (fifo_cnt == 2'd0) && !inflight_q;

  assign Busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign Done     = (state_q == ST_DRAIN) && drained;
  assign Mem_RdEn = issue;
  assign Mem_Addr = AddrWidth'(int'(ot_q) * O_TileSize + int'(ob_q) * O_PEGroupSize +
                               int'(wt_q) * W_TileSize + int'(k_q));

  always_comb begin
    state_d = state_q;
    ot_d    = ot_q;
    ob_d    = ob_q;
    wt_d    = wt_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_RUN;
          ot_d    = '0;
          ob_d    = '0;
          wt_d    = '0;
          k_d     = '0;
        end
      end
      ST_RUN: begin
        if (issue) begin
          // Nested loop advance, k innermost; all wrap to zero on the last address
          if (k_q == KLast) begin
            k_d = '0;
            if (wt_q == WtLast) begin
              wt_d = '0;
              if (ob_q == ObLast) begin
                ob_d = '0;
                ot_d = (ot_q == OtLast) ? '0 : ot_q + OtW'(1);
              end else begin
                ob_d = ob_q + ObW'(1);
              end
            end else begin
              wt_d = wt_q + WtW'(1);
            end
          end else begin
            k_d = k_q + KW'(1);
          end
          if (last_addr) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drained) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q    <= ST_IDLE;
      ot_q       <= '0;
      ob_q       <= '0;
      wt_q       <= '0;
      k_q        <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ot_q       <= ot_d;
      ob_q       <= ob_d;
      wt_q       <= wt_d;
      k_q        <= k_d;
      inflight_q <= issue;
    end
  end

  // Read data lands exactly one cycle after issue, tracked by inflight_q
  stream_skid_fifo #(
    .DataWidth (DataWidth)
  ) u_fifo (
    .clk       (clk),
    .aclr      (aclr),
    .in_vld_i  (inflight_q),
    .in_dat_i  (Mem_RdData),
    .out_vld_o (I_DataOutValid),
    .out_dat_o (I_DataOut),
    .out_rdy_i (I_DataOutRdy),
    .count_o   (fifo_cnt)
  );

endmodule

// File: tb/tb_input_stream_feeder.sv
`timescale 1ns/1ps
module tb_input_stream_feeder;

  localparam int DW = 32;
  localparam int AW = 8;

  typedef struct {
    int rdy_mode;      // 0 always ready, 1 alternate 1/0, 2 random
    int restart_beat;  // re-pulse Start once this many beats arrived, -1 never
    bit start_on_done; // pulse Start in the Done cycle
    bit check_timing;  // verify first-beat latency, back-to-back beats, Done gap
    int exp_beats;
    int exp_dones;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          aclr, start, rdy;
  logic          busy, done, rden, vld;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata, dout;
  logic          busy2, done2, rden2, vld2;
  logic [AW-1:0] addr2;
  logic [DW-1:0] rdata2, dout2;

  input_stream_feeder #(.DataWidth(DW), .AddrWidth(AW)) dut (
    .clk(clk), .aclr(aclr), .Start(start), .Busy(busy), .Done(done),
    .Mem_RdEn(rden), .Mem_Addr(addr), .Mem_RdData(rdata),
    .I_DataOutValid(vld), .I_DataOutRdy(rdy), .I_DataOut(dout)
  );

  input_stream_feeder #(.DataWidth(DW), .AddrWidth(AW), .O_TileSize(8), .O_PEGroupSize(4)) dut2 (
    .clk(clk), .aclr(aclr), .Start(start), .Busy(busy2), .Done(done2),
    .Mem_RdEn(rden2), .Mem_Addr(addr2), .Mem_RdData(rdata2),
    .I_DataOutValid(vld2), .I_DataOutRdy(rdy), .I_DataOut(dout2)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int beats, dones, reads, beats2, dones2;
  int first_vld_cyc, last_cyc, done_cyc, nonconsec;
  logic          held_vld = 1'b0, held_vld2 = 1'b0;
  logic [DW-1:0] held_dat, held_dat2;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp2_q[$];

  // Memory model: word = address, one-cycle read latency; poison when not read
  always @(posedge clk) begin
    rdata  <= rden  ? DW'(addr)  : 32'hDEAD_BEEF;
    rdata2 <= rden2 ? DW'(addr2) : 32'hDEAD_BEEF;
    cyc    <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stream monitor / scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (held_vld) begin
      check("stall_hold_vld", vld, 1);
      check("stall_hold_data", dout, held_dat);
    end
    if (held_vld2) begin
      check("stall_hold_vld2", vld2, 1);
      check("stall_hold_data2", dout2, held_dat2);
    end
    if (vld && rdy) begin
      check("beat_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("beat_data", dout, exp_q.pop_front());
      if (beats > 0 && cyc != last_cyc + 1) nonconsec++;
      last_cyc = cyc;
      beats++;
    end
    if (vld2 && rdy) begin
      check("beat_expected2", exp2_q.size() > 0, 1);
      if (exp2_q.size() > 0) check("beat_data2", dout2, exp2_q.pop_front());
      beats2++;
    end
    if (vld && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (done) begin dones++; done_cyc = cyc; end
    if (done2) dones2++;
    if (rden) begin reads++; check("rden_only_busy", busy, 1); end
    held_vld  = vld && !rdy && !aclr;
    held_dat  = dout;
    held_vld2 = vld2 && !rdy && !aclr;
    held_dat2 = dout2;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference address order: nested loops straight from the tiling definition
  task automatic gen_one(input int which, input int o_size, input int o_tile, input int o_peg,
                         input int w_size, input int w_tile);
    for (int ot = 0; ot < o_size / o_tile; ot++)
      for (int ob = 0; ob < o_tile / o_peg; ob++)
        for (int wt = 0; wt < w_size / w_tile; wt++)
          for (int k = 0; k < o_peg + w_tile - 1; k++) begin
            logic [AW-1:0] a;
            a = AW'(ot * o_tile + ob * o_peg + wt * w_tile + k);
            if (which == 0) exp_q.push_back(DW'(a));
            else exp2_q.push_back(DW'(a));
          end
  endtask

  task automatic gen_expected();
    exp_q.delete();
    exp2_q.delete();
    gen_one(0, 8, 4, 4, 8, 8);
    gen_one(1, 8, 8, 4, 8, 8);
  endtask

  task automatic clear_counts();
    beats = 0; dones = 0; reads = 0; beats2 = 0; dones2 = 0;
    first_vld_cyc = -1; last_cyc = 0; done_cyc = 0; nonconsec = 0;
  endtask

  task automatic wait_idle(input string tag);
    bit finished = 0;
    for (int t = 0; t < 400 && !finished; t++) begin
      step();
      finished = (dones >= 1) && (dones2 >= 1) && !busy && !busy2;
    end
    check({tag, "_completed"}, finished, 1);
  endtask

  task automatic run_pass(input vec_t v, input string tag);
    bit restarted = 0;
    bit finished = 0;
    int start_cyc;
    clear_counts();
    gen_expected();
    rdy = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    start_cyc = cyc;
    for (int t = 0; t < 400 && !finished; t++) begin
      case (v.rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (t % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (v.restart_beat >= 0 && !restarted && beats >= v.restart_beat) begin
        start = 1'b1;
        restarted = 1;
      end
      if (v.start_on_done && done) start = 1'b1;
      step();
      start = 1'b0;
      finished = (dones >= 1) && (dones2 >= 1) && !busy && !busy2;
    end
    check({tag, "_completed"}, finished, 1);
    rdy = 1'b1;
    repeat (5) step();
    check({tag, "_beats"}, beats, v.exp_beats);
    check({tag, "_dones"}, dones, v.exp_dones);
    check({tag, "_reads"}, reads, v.exp_beats);
    check({tag, "_leftover"}, exp_q.size(), 0);
    check({tag, "_beats_ob"}, beats2, v.exp_beats);
    check({tag, "_dones_ob"}, dones2, v.exp_dones);
    check({tag, "_leftover_ob"}, exp2_q.size(), 0);
    check({tag, "_idle"}, busy, 0);
    if (v.check_timing) begin
      check({tag, "_first_beat_latency"}, first_vld_cyc - start_cyc, 2);
      check({tag, "_back_to_back"}, nonconsec, 0);
      check({tag, "_done_gap"}, done_cyc - last_cyc, 1);
    end
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{rdy_mode: 0, restart_beat: -1, start_on_done: 0, check_timing: 1, exp_beats: 22, exp_dones: 1};
    vecs[1] = '{rdy_mode: 1, restart_beat: -1, start_on_done: 0, check_timing: 0, exp_beats: 22, exp_dones: 1};
    vecs[2] = '{rdy_mode: 0, restart_beat: 5,  start_on_done: 0, check_timing: 1, exp_beats: 22, exp_dones: 1};
    vecs[3] = '{rdy_mode: 2, restart_beat: -1, start_on_done: 0, check_timing: 0, exp_beats: 22, exp_dones: 1};
    vecs[4] = '{rdy_mode: 0, restart_beat: -1, start_on_done: 1, check_timing: 1, exp_beats: 22, exp_dones: 1};

    // Reset values
    aclr = 1'b1; start = 1'b0; rdy = 1'b1;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rden", rden, 0);
    check("rst_addr", addr, 0);
    check("rst_vld", vld, 0);
    check("rst_dout", dout, 0);
    aclr = 1'b0;
    step();

    for (int i = 0; i < 5; i++) run_pass(vecs[i], $sformatf("vec%0d", i));

    // Sink stalled from Start: only two reads may be outstanding
    clear_counts();
    gen_expected();
    rdy = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    check("stall_reads", reads, 2);
    check("stall_rden_low", rden, 0);
    check("stall_vld", vld, 1);
    check("stall_head", dout, 0);
    rdy = 1'b1;
    wait_idle("stall");
    check("stall_beats", beats, 22);
    check("stall_dones", dones, 1);
    check("stall_leftover", exp_q.size(), 0);

    // Reset mid-pass at beat 7, with a read issued in the reset cycle
    clear_counts();
    gen_expected();
    rdy = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 100 && beats < 7; t++) step();
    check("abort_at_beat7", beats, 7);
    aclr = 1'b1;
    step();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rden", rden, 0);
    check("abort_addr", addr, 0);
    check("abort_vld", vld, 0);
    check("abort_dout", dout, 0);
    aclr = 1'b0;
    exp_q.delete();
    exp2_q.delete();
    step();
    check("abort_late_data_dropped", vld, 0);
    repeat (5) step();
    check("abort_no_done", dones, 0);
    check("abort_idle", busy, 0);
    run_pass(vecs[0], "after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
